// File: rtl/aha_axi_sif_rd_data_pipe.sv
// AXI read-data return pipe for the SIF slave interface.
// Accepted AR bursts are queued as {ID, LEN} in a command queue; SIF read
// beats are queued as {ERR, DATA} in a data queue. R beats are issued when
// both queues have an entry, and each burst ends after LEN+1 beats.
// Every R output comes from queue storage, so nothing from SIF reaches R
// combinationally.
module aha_axi_sif_rd_data_pipe #(
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int DATA_DEPTH = 32,
  parameter int CMD_DEPTH  = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   ARID,
  input  logic [7:0]        ARLEN,
  input  logic              ARVALID,
  input  logic              ARREADY,
  output logic              CMD_FULL,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              RLAST,
  output logic [DATA_W-1:0] RDATA,
  output logic [ID_W-1:0]   RID,
  output logic [1:0]        RRESP,
  input  logic [DATA_W-1:0] SIF_RD_DATA,
  input  logic              SIF_RD_VALID,
  input  logic              SIF_RD_ERR,
  output logic              SIF_RD_READY,
  output logic              ERR_OVF
);

  localparam int CMD_AW  = $clog2(CMD_DEPTH);
  localparam int DATA_AW = $clog2(DATA_DEPTH);

  localparam logic [CMD_AW-1:0]  CMD_PTR_ONE   = CMD_AW'(1);
  localparam logic [CMD_AW:0]    CMD_CNT_ONE   = (CMD_AW + 1)'(1);
  localparam logic [CMD_AW:0]    CMD_CNT_FULL  = (CMD_AW + 1)'(CMD_DEPTH);
  localparam logic [DATA_AW-1:0] DATA_PTR_ONE  = DATA_AW'(1);
  localparam logic [DATA_AW:0]   DATA_CNT_ONE  = (DATA_AW + 1)'(1);
  localparam logic [DATA_AW:0]   DATA_CNT_FULL = (DATA_AW + 1)'(DATA_DEPTH);

  // ---------------------------------------------------------------------------
  // Command queue storage and control
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0]   cmd_id_mem  [CMD_DEPTH];
  logic [7:0]        cmd_len_mem [CMD_DEPTH];
  logic [CMD_AW-1:0] cmd_wr_ptr;
  logic [CMD_AW-1:0] cmd_rd_ptr;
  logic [CMD_AW:0]   cmd_cnt;
  logic [CMD_AW:0]   cmd_cnt_nxt;
  logic              cmd_full_q;
  logic              cmd_nonempty;
  logic              ar_accept;
  logic              cmd_push;
  logic              cmd_pop;
  logic [ID_W-1:0]   head_id;
  logic [7:0]        head_len;

  // ---------------------------------------------------------------------------
  // Data queue storage and control
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]    data_mem [DATA_DEPTH];
  logic [DATA_AW-1:0] data_wr_ptr;
  logic [DATA_AW-1:0] data_rd_ptr;
  logic [DATA_AW:0]   data_cnt;
  logic [DATA_AW:0]   data_cnt_nxt;
  logic               data_full;
  logic               data_nonempty;
  logic               data_push;
  logic               data_pop;
  logic [DATA_W:0]    head_beat;

  // ---------------------------------------------------------------------------
  // R channel state
  // ---------------------------------------------------------------------------
  logic [7:0] beat_cnt;
  logic       r_valid;
  logic       r_last;
  logic       r_hs;
  logic       ovf_event;

  // The AR handshake is observed here, not owned; an accept while full is
  // dropped because the upstream was told to stall via CMD_FULL.
  assign ar_accept    = ARVALID & ARREADY;
  assign cmd_push     = ar_accept & ~cmd_full_q;
  assign cmd_nonempty = (cmd_cnt != '0);
  assign head_id      = cmd_id_mem[cmd_rd_ptr];
  assign head_len     = cmd_len_mem[cmd_rd_ptr];

  assign data_full     = (data_cnt == DATA_CNT_FULL);
  assign data_nonempty = (data_cnt != '0);
  assign data_push     = SIF_RD_VALID & ~data_full;
  assign head_beat     = data_mem[data_rd_ptr];

  // A beat may leave only once its burst is known; data arriving ahead of
  // its AR waits in the data queue.
  assign r_valid  = data_nonempty & cmd_nonempty;
  assign r_hs     = r_valid & RREADY;
  assign r_last   = r_valid & (beat_cnt == head_len);
  assign cmd_pop  = r_hs & r_last;
  assign data_pop = r_hs;

  assign ovf_event = (ar_accept & cmd_full_q) | (SIF_RD_VALID & data_full);

  // Next command-queue occupancy; push and pop together leave it unchanged.
  always_comb begin
    cmd_cnt_nxt = cmd_cnt;
    case ({cmd_push, cmd_pop})
      2'b10:   cmd_cnt_nxt = cmd_cnt + CMD_CNT_ONE;
      2'b01:   cmd_cnt_nxt = cmd_cnt - CMD_CNT_ONE;
      default: cmd_cnt_nxt = cmd_cnt;
    endcase
  end

  // Next data-queue occupancy; push and pop together leave it unchanged.
  always_comb begin
    data_cnt_nxt = data_cnt;
    case ({data_push, data_pop})
      2'b10:   data_cnt_nxt = data_cnt + DATA_CNT_ONE;
      2'b01:   data_cnt_nxt = data_cnt - DATA_CNT_ONE;
      default: data_cnt_nxt = data_cnt;
    endcase
  end

  // Command queue payload; not reset since reads are qualified by occupancy.
  always_ff @(posedge ACLK) begin
    if (cmd_push) begin
      cmd_id_mem[cmd_wr_ptr]  <= ARID;
      cmd_len_mem[cmd_wr_ptr] <= ARLEN;
    end
  end

  // Command queue pointers, occupancy and the registered full flag.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_cnt    <= '0;
      cmd_full_q <= 1'b0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CMD_PTR_ONE;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CMD_PTR_ONE;
      cmd_cnt    <= cmd_cnt_nxt;
      cmd_full_q <= (cmd_cnt_nxt == CMD_CNT_FULL);
    end
  end

  // Data queue payload with the per-beat error bit in the MSB.
  always_ff @(posedge ACLK) begin
    if (data_push) begin
      data_mem[data_wr_ptr] <= {SIF_RD_ERR, SIF_RD_DATA};
    end
  end

  // Data queue pointers and occupancy.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      data_wr_ptr <= '0;
      data_rd_ptr <= '0;
      data_cnt    <= '0;
    end else begin
      if (data_push) data_wr_ptr <= data_wr_ptr + DATA_PTR_ONE;
      if (data_pop)  data_rd_ptr <= data_rd_ptr + DATA_PTR_ONE;
      data_cnt <= data_cnt_nxt;
    end
  end

  // Beat position within the head burst; restarts when the burst retires.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      beat_cnt <= 8'd0;
    end else if (cmd_pop) begin
      beat_cnt <= 8'd0;
    end else if (r_hs) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  // Sticky record of any dropped AR or SIF beat; only reset clears it.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ERR_OVF <= 1'b0;
    end else if (ovf_event) begin
      ERR_OVF <= 1'b1;
    end
  end

  // Payload outputs are forced to zero when idle so reset and empty states
  // never expose stale queue contents. While a beat is stalled the head
  // entries cannot move, which keeps RDATA/RRESP/RID stable.
  assign CMD_FULL     = cmd_full_q;
  assign SIF_RD_READY = ~data_full;
  assign RVALID       = r_valid;
  assign RLAST        = r_last;
  assign RDATA        = r_valid ? head_beat[DATA_W-1:0] : '0;
  assign RRESP        = (r_valid && head_beat[DATA_W]) ? 2'b10 : 2'b00;
  assign RID          = cmd_nonempty ? head_id : '0;

endmodule

// File: tb/tb_aha_axi_sif_rd_data_pipe.sv
// Directed bench for aha_axi_sif_rd_data_pipe: single burst, back-to-back
// bursts, backpressure, command overflow, error beat and reset mid-burst.
module tb_aha_axi_sif_rd_data_pipe;

  localparam int DATA_W = 64;
  localparam int ID_W   = 4;

  logic              ACLK;
  logic              ARESETn;
  logic [ID_W-1:0]   ARID;
  logic [7:0]        ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  logic              CMD_FULL;
  logic              RVALID;
  logic              RREADY;
  logic              RLAST;
  logic [DATA_W-1:0] RDATA;
  logic [ID_W-1:0]   RID;
  logic [1:0]        RRESP;
  logic [DATA_W-1:0] SIF_RD_DATA;
  logic              SIF_RD_VALID;
  logic              SIF_RD_ERR;
  logic              SIF_RD_READY;
  logic              ERR_OVF;

  aha_axi_sif_rd_data_pipe #(
    .DATA_W(DATA_W), .ID_W(ID_W), .DATA_DEPTH(32), .CMD_DEPTH(4)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID(ARID), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .CMD_FULL(CMD_FULL),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RDATA(RDATA),
    .RID(RID), .RRESP(RRESP),
    .SIF_RD_DATA(SIF_RD_DATA), .SIF_RD_VALID(SIF_RD_VALID),
    .SIF_RD_ERR(SIF_RD_ERR), .SIF_RD_READY(SIF_RD_READY),
    .ERR_OVF(ERR_OVF)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic              last;
    logic [1:0]        resp;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    got_beats = 0;
  int    cycle = 0;
  int    pushed = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_beat(input logic [DATA_W-1:0] d, input logic [ID_W-1:0] id,
                             input logic last, input logic [1:0] resp);
    beat_t b;
    b.data = d; b.id = id; b.last = last; b.resp = resp;
    exp_q.push_back(b);
  endtask

  // One clock: observe any R handshake mid-cycle, then return just after
  // the next rising edge so the caller can drive new inputs.
  task automatic tick();
    beat_t e;
    @(negedge ACLK);
    if (RVALID && RREADY) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat: observed RDATA %0h RID %0h expected no beat", RDATA, RID);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rdata", RDATA, e.data);
        chk("rid",   64'(RID),   64'(e.id));
        chk("rlast", 64'(RLAST), 64'(e.last));
        chk("rresp", 64'(RRESP), 64'(e.resp));
      end
      got_beats++;
      beat_cyc.push_back(cycle);
    end
    @(posedge ACLK);
    #1;
    cycle++;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn = 1'b0; ARID = '0; ARLEN = '0; ARVALID = 1'b0; ARREADY = 1'b0;
    RREADY = 1'b0; SIF_RD_DATA = '0; SIF_RD_VALID = 1'b0; SIF_RD_ERR = 1'b0;

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_rvalid",   64'(RVALID),   64'd0);
    chk("rst_rlast",    64'(RLAST),    64'd0);
    chk("rst_rdata",    RDATA,         64'd0);
    chk("rst_rid",      64'(RID),      64'd0);
    chk("rst_rresp",    64'(RRESP),    64'd0);
    chk("rst_cmd_full", 64'(CMD_FULL), 64'd0);
    chk("rst_err_ovf",  64'(ERR_OVF),  64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    chk("rst_sif_ready", 64'(SIF_RD_READY), 64'd1);

    // Single burst: ID 3, four beats A0..A3
    got_beats = 0;
    for (int i = 0; i < 4; i++) expect_beat(64'hA0 + 64'(i), 4'd3, (i == 3), 2'b00);
    ARID = 4'd3; ARLEN = 8'd3; ARVALID = 1'b1; ARREADY = 1'b1;
    RREADY = 1'b1; SIF_RD_VALID = 1'b1; SIF_RD_DATA = 64'hA0;
    #1;
    chk("t1_no_comb_path", 64'(RVALID), 64'd0);
    tick();
    ARVALID = 1'b0;
    for (int i = 1; i < 4; i++) begin
      SIF_RD_DATA = 64'hA0 + 64'(i);
      tick();
    end
    SIF_RD_VALID = 1'b0;
    repeat (3) tick();
    chk("t1_beats",   64'(got_beats),    64'd4);
    chk("t1_pending", 64'(exp_q.size()), 64'd0);

    // Back-to-back bursts: ID 1 LEN 0, ID 2 LEN 1, data streamed continuously
    got_beats = 0;
    beat_cyc.delete();
    expect_beat(64'hB0, 4'd1, 1'b1, 2'b00);
    expect_beat(64'hB1, 4'd2, 1'b0, 2'b00);
    expect_beat(64'hB2, 4'd2, 1'b1, 2'b00);
    ARID = 4'd1; ARLEN = 8'd0; ARVALID = 1'b1;
    SIF_RD_VALID = 1'b1; SIF_RD_DATA = 64'hB0;
    tick();
    ARID = 4'd2; ARLEN = 8'd1; SIF_RD_DATA = 64'hB1;
    tick();
    ARVALID = 1'b0; SIF_RD_DATA = 64'hB2;
    tick();
    SIF_RD_VALID = 1'b0;
    repeat (3) tick();
    chk("t2_beats", 64'(got_beats), 64'd3);
    if (beat_cyc.size() == 3) chk("t2_no_bubble", 64'(beat_cyc[2] - beat_cyc[0]), 64'd2);
    chk("t2_pending", 64'(exp_q.size()), 64'd0);

    // Backpressure: 40-beat burst, RREADY low, source honours SIF_RD_READY
    got_beats = 0;
    for (int i = 0; i < 40; i++) expect_beat(64'h100 + 64'(i), 4'd5, (i == 39), 2'b00);
    RREADY = 1'b0;
    ARID = 4'd5; ARLEN = 8'd39; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    pushed = 0;
    for (int c = 0; c < 40; c++) begin
      if (SIF_RD_READY) begin
        SIF_RD_VALID = 1'b1; SIF_RD_DATA = 64'h100 + 64'(pushed); pushed++;
      end else begin
        SIF_RD_VALID = 1'b0;
      end
      tick();
    end
    SIF_RD_VALID = 1'b0;
    chk("t3_pushed_before_stall", 64'(pushed), 64'd32);
    chk("t3_sif_ready_low",       64'(SIF_RD_READY), 64'd0);
    chk("t3_no_ovf",              64'(ERR_OVF), 64'd0);
    chk("t3_held_rdata",          RDATA, 64'h100);
    RREADY = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (pushed < 40 && SIF_RD_READY) begin
        SIF_RD_VALID = 1'b1; SIF_RD_DATA = 64'h100 + 64'(pushed); pushed++;
      end else begin
        SIF_RD_VALID = 1'b0;
      end
      tick();
    end
    SIF_RD_VALID = 1'b0;
    chk("t3_beats",   64'(got_beats),    64'd40);
    chk("t3_pending", 64'(exp_q.size()), 64'd0);
    chk("t3_no_ovf_end", 64'(ERR_OVF),   64'd0);

    // Command overflow: five forced AR accepts, no drain
    got_beats = 0;
    RREADY = 1'b0;
    for (int i = 0; i < 4; i++) expect_beat(64'h200 + 64'(i), 4'(6 + i), 1'b1, 2'b00);
    ARVALID = 1'b1; ARREADY = 1'b1; ARLEN = 8'd0;
    for (int i = 0; i < 4; i++) begin
      ARID = 4'(6 + i);
      tick();
    end
    chk("t4_cmd_full_after4", 64'(CMD_FULL), 64'd1);
    chk("t4_no_ovf_yet",      64'(ERR_OVF),  64'd0);
    ARID = 4'd10;
    tick();
    ARVALID = 1'b0;
    chk("t4_err_ovf", 64'(ERR_OVF),  64'd1);
    chk("t4_rid_head", 64'(RID),     64'd6);
    RREADY = 1'b1; SIF_RD_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      SIF_RD_DATA = 64'h200 + 64'(i);
      tick();
    end
    SIF_RD_VALID = 1'b0;
    repeat (4) tick();
    chk("t4_beats",        64'(got_beats),    64'd4);
    chk("t4_pending",      64'(exp_q.size()), 64'd0);
    chk("t4_data_held",    64'(RVALID),       64'd0);
    chk("t4_cmd_not_full", 64'(CMD_FULL),     64'd0);
    chk("t4_ovf_sticky",   64'(ERR_OVF),      64'd1);
    ARESETn = 1'b0;
    #1;
    chk("t4_ovf_cleared_by_reset", 64'(ERR_OVF), 64'd0);
    do_reset();

    // Error beat: LEN 1, second beat carries SIF_RD_ERR
    got_beats = 0;
    expect_beat(64'hC0, 4'd4, 1'b0, 2'b00);
    expect_beat(64'hC1, 4'd4, 1'b1, 2'b10);
    ARID = 4'd4; ARLEN = 8'd1; ARVALID = 1'b1;
    SIF_RD_VALID = 1'b1; SIF_RD_DATA = 64'hC0; SIF_RD_ERR = 1'b0;
    tick();
    ARVALID = 1'b0; SIF_RD_DATA = 64'hC1; SIF_RD_ERR = 1'b1;
    tick();
    SIF_RD_VALID = 1'b0; SIF_RD_ERR = 1'b0;
    repeat (3) tick();
    chk("t5_beats",   64'(got_beats),    64'd2);
    chk("t5_pending", 64'(exp_q.size()), 64'd0);

    // Reset mid-burst after 2 of 4 beats, then a fresh single-beat burst
    got_beats = 0;
    RREADY = 1'b0;
    ARID = 4'd2; ARLEN = 8'd3; ARVALID = 1'b1; SIF_RD_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SIF_RD_DATA = 64'hD0 + 64'(i);
      tick();
      ARVALID = 1'b0;
    end
    SIF_RD_VALID = 1'b0;
    expect_beat(64'hD0, 4'd2, 1'b0, 2'b00);
    expect_beat(64'hD1, 4'd2, 1'b0, 2'b00);
    RREADY = 1'b1;
    repeat (2) tick();
    chk("t6_two_beats", 64'(got_beats), 64'd2);
    ARESETn = 1'b0;
    #1;
    chk("t6_rvalid_in_reset", 64'(RVALID), 64'd0);
    chk("t6_rlast_in_reset",  64'(RLAST),  64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    chk("t6_rvalid_after_reset", 64'(RVALID), 64'd0);
    expect_beat(64'hE0, 4'd7, 1'b1, 2'b00);
    ARID = 4'd7; ARLEN = 8'd0; ARVALID = 1'b1;
    SIF_RD_VALID = 1'b1; SIF_RD_DATA = 64'hE0;
    tick();
    ARVALID = 1'b0; SIF_RD_VALID = 1'b0;
    repeat (4) tick();
    chk("t6_total_beats", 64'(got_beats),    64'd3);
    chk("t6_pending",     64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
